game_card_dealer: RTL and testbench

GAME_CARD_DEALER -- requirements
Module: game_card_dealer

---
 rtl/game_card_dealer.sv | 91 +++++++++
 tb/tb_game_card_dealer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_card_dealer.sv
// game_card_dealer: deals cards from a 52-card deck to a master and a slave player using an LFSR-driven rank draw.
module game_card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       new_Game,
    input  logic       reqMaster,
    input  logic       reqSlave,
    input  logic       finishMaster,
    input  logic       finishSlave,
    output logic [3:0] cardValue4,
    output logic       cardReadyMaster,
    output logic       cardReadySlave,
    output logic [5:0] cardsLeft,
    output logic       deckEmpty,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, DRAW, CHECK, ISSUE, EMPTY} state_t;
    state_t           state_q, state_d;
    logic [15:0]      lfsr_q;
    logic             sel_q, sel_d, last_q, last_d;
    logic [3:0]       rank_q, rank_d, val_q, val_d;
    logic [5:0]       cards_q, cards_d;
    logic [12:0][2:0] cnt_q, cnt_d;
    logic             elig_m, elig_s;
    logic [3:0]       draw, ridx;
    assign elig_m = reqMaster & ~finishMaster;
    assign elig_s = reqSlave & ~finishSlave;
    assign draw   = lfsr_q[3:0];
    assign ridx   = rank_q - 4'd1;
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        rank_d  = rank_q;
        val_d   = val_q;
        cards_d = cards_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (elig_m || elig_s) begin
                sel_d   = (elig_m && elig_s) ? ~last_q : elig_s;
                state_d = DRAW;
            end
            DRAW: if (draw >= 4'd1 && draw <= 4'd13) begin
                rank_d  = draw;
                state_d = CHECK;
            end
            CHECK: if (cnt_q[ridx] == 3'd4) begin
                state_d = DRAW;
            end else begin
                cnt_d[ridx] = cnt_q[ridx] + 3'd1;
                cards_d     = cards_q - 6'd1;
                val_d       = (rank_q == 4'd1) ? 4'd11 : (rank_q > 4'd10) ? 4'd10 : rank_q;
                state_d     = ISSUE;
            end
            ISSUE: begin
                last_d  = sel_q;
                state_d = (cards_q == 6'd0) ? EMPTY : IDLE;
            end
            EMPTY:   state_d = EMPTY;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge new_Game) begin
        if (new_Game) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            rank_q  <= 4'd0;
            val_q   <= 4'd0;
            cards_q <= 6'd52;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            sel_q   <= sel_d;
            last_q  <= last_d;
            rank_q  <= rank_d;
            val_q   <= val_d;
            cards_q <= cards_d;
            cnt_q   <= cnt_d;
        end
    end
    assign cardValue4      = val_q;
    assign cardsLeft       = cards_q;
    assign deckEmpty       = (cards_q == 6'd0);
    assign busy            = (state_q == DRAW) || (state_q == CHECK) || (state_q == ISSUE);
    assign cardReadyMaster = (state_q == ISSUE) && !sel_q;
    assign cardReadySlave  = (state_q == ISSUE) && sel_q;
endmodule

// File: tb/tb_game_card_dealer.sv
// tb_game_card_dealer: randomized and directed checks of the card dealer against a deck-level model.
module tb_game_card_dealer;
    logic       clock = 1'b0;
    logic       new_Game = 1'b0, reqMaster = 1'b0, reqSlave = 1'b0, finishMaster = 1'b0, finishSlave = 1'b0;
    logic [3:0] cardValue4;
    logic       cardReadyMaster, cardReadySlave, deckEmpty, busy;
    logic [5:0] cardsLeft;
    int         checks = 0, failures = 0;
    int         m_cards;
    int         m_hist[16];
    bit         m_last_slave;
    always #5 clock = ~clock;
    game_card_dealer dut (
        .clock(clock), .new_Game(new_Game), .reqMaster(reqMaster), .reqSlave(reqSlave),
        .finishMaster(finishMaster), .finishSlave(finishSlave), .cardValue4(cardValue4),
        .cardReadyMaster(cardReadyMaster), .cardReadySlave(cardReadySlave),
        .cardsLeft(cardsLeft), .deckEmpty(deckEmpty), .busy(busy)
    );
    always @(negedge clock) if (cardReadyMaster && cardReadySlave) begin
        failures++;
        $display("FAIL both_ready: master=%0b slave=%0b required not both high", cardReadyMaster, cardReadySlave);
    end
    function automatic int cap(input int v);
        return (v == 10) ? 16 : 4;
    endfunction
    task automatic model_reset();
        m_cards = 52;
        m_last_slave = 1'b1;
        foreach (m_hist[i]) m_hist[i] = 0;
    endtask
    task automatic pulse_reset();
        reqMaster = 0; reqSlave = 0; finishMaster = 0; finishSlave = 0;
        new_Game = 1;
        repeat (2) @(negedge clock);
        new_Game = 0;
        model_reset();
    endtask
    task automatic wait_pulse(input int budget, output bit got, output bit who, output int cyc);
        got = 0; who = 0; cyc = 0;
        while (!got && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (cardReadyMaster || cardReadySlave) begin
                got = 1;
                who = cardReadySlave;
            end
        end
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
    endtask
    task automatic test_reset();
        new_Game = 1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_async_busy: got %0b want 0", busy); end
        pulse_reset();
        checks++; if (cardsLeft !== 6'd52) begin failures++; $display("FAIL reset_cards: got %0d want 52", cardsLeft); end
        checks++; if (cardValue4 !== 4'd0) begin failures++; $display("FAIL reset_value: got %0d want 0", cardValue4); end
        checks++; if ({cardReadyMaster, cardReadySlave} !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b want 00", {cardReadyMaster, cardReadySlave}); end
        checks++; if (deckEmpty !== 1'b0) begin failures++; $display("FAIL reset_empty: got %0b want 0", deckEmpty); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    endtask
    task automatic test_single();
        bit got, who;
        int cyc, extra;
        logic [3:0] v;
        reqMaster = 1;
        @(negedge clock);
        reqMaster = 0;
        wait_pulse(2000, got, who, cyc);
        checks++; if (!got || who) begin failures++; $display("FAIL single_who: got=%0b slave=%0b want master pulse", got, who); end
        checks++; if (cyc + 1 < 3) begin failures++; $display("FAIL single_latency: got %0d want >=3", cyc + 1); end
        v = cardValue4;
        checks++; if (v < 4'd2 || v > 4'd11) begin failures++; $display("FAIL single_value: got %0d want 2..11", v); end
        checks++; if (cardsLeft !== 6'd51) begin failures++; $display("FAIL single_cards: got %0d want 51", cardsLeft); end
        m_cards = 51; m_hist[v]++; m_last_slave = 0;
        extra = 0;
        repeat (12) begin
            @(negedge clock);
            if (cardReadyMaster || cardReadySlave || cardValue4 !== v) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL single_hold: got %0d bad cycles want 0", extra); end
    endtask
    task automatic test_alternation();
        bit got, who;
        int cyc;
        pulse_reset();
        reqMaster = 1; reqSlave = 1;
        for (int k = 0; k < 8; k++) begin
            wait_pulse(2000, got, who, cyc);
            checks++; if (!got || who !== bit'(k % 2)) begin failures++; $display("FAIL alt_order[%0d]: got=%0b slave=%0b want slave=%0b", k, got, who, k % 2); end
            checks++; if (cyc < 3) begin failures++; $display("FAIL alt_spacing[%0d]: got %0d want >=3", k, cyc); end
            if (got) begin
                m_cards--; m_hist[cardValue4]++; m_last_slave = who;
                checks++; if (cardsLeft !== 6'(m_cards) || m_hist[cardValue4] > cap(int'(cardValue4))) begin failures++; $display("FAIL alt_deck[%0d]: cards=%0d want %0d value=%0d", k, cardsLeft, m_cards, cardValue4); end
            end
        end
        reqMaster = 0; reqSlave = 0;
        @(negedge clock);
        wait_idle();
    endtask
    task automatic test_finish_gating();
        int n = 0;
        wait_idle();
        finishSlave = 1; reqSlave = 1;
        repeat (200) begin
            @(negedge clock);
            if (cardReadySlave || cardReadyMaster) n++;
        end
        checks++; if (n != 0) begin failures++; $display("FAIL finish_pulses: got %0d want 0", n); end
        checks++; if (cardsLeft !== 6'(m_cards)) begin failures++; $display("FAIL finish_cards: got %0d want %0d", cardsLeft, m_cards); end
        finishSlave = 0; reqSlave = 0;
    endtask
    task automatic test_random();
        bit got, who, rm, rs, fm, fs, em, es, exp_slave;
        int cyc;
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            rm = 1'($urandom); rs = 1'($urandom); fm = 1'($urandom_range(0, 3) == 0); fs = 1'($urandom_range(0, 3) == 0);
            em = rm && !fm; es = rs && !fs;
            reqMaster = rm; reqSlave = rs; finishMaster = fm; finishSlave = fs;
            @(negedge clock);
            reqMaster = 0; reqSlave = 0;
            if (!em && !es) begin
                wait_pulse(10, got, who, cyc);
                checks++; if (got || cardsLeft !== 6'(m_cards)) begin failures++; $display("FAIL rand_idle[%0d]: pulse=%0b cards=%0d want none/%0d", it, got, cardsLeft, m_cards); end
            end else begin
                exp_slave = (em && es) ? !m_last_slave : es;
                wait_pulse(2000, got, who, cyc);
                checks++; if (!got || who !== exp_slave) begin failures++; $display("FAIL rand_who[%0d]: got=%0b slave=%0b want slave=%0b", it, got, who, exp_slave); end
                if (got) begin
                    m_cards--; m_hist[cardValue4]++; m_last_slave = who;
                    checks++; if (cardsLeft !== 6'(m_cards) || cardValue4 < 4'd2 || cardValue4 > 4'd11 || m_hist[cardValue4] > cap(int'(cardValue4))) begin failures++; $display("FAIL rand_deck[%0d]: cards=%0d want %0d value=%0d", it, cardsLeft, m_cards, cardValue4); end
                end
            end
            finishMaster = 0; finishSlave = 0;
        end
    endtask
    task automatic test_reset_mid_deal();
        bit got, who;
        int cyc, n = 0;
        wait_idle();
        reqMaster = 1;
        @(negedge clock);
        reqMaster = 0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL middeal_busy: got %0b want 1", busy); end
        new_Game = 1;
        #1;
        checks++; if (cardsLeft !== 6'd52 || busy !== 1'b0) begin failures++; $display("FAIL middeal_async: cards=%0d busy=%0b want 52/0", cardsLeft, busy); end
        repeat (3) begin
            @(negedge clock);
            if (cardReadyMaster || cardReadySlave) n++;
        end
        new_Game = 0;
        model_reset();
        repeat (10) begin
            @(negedge clock);
            if (cardReadyMaster || cardReadySlave) n++;
        end
        checks++; if (n != 0 || cardsLeft !== 6'd52) begin failures++; $display("FAIL middeal_abort: pulses=%0d cards=%0d want 0/52", n, cardsLeft); end
        reqMaster = 1;
        @(negedge clock);
        reqMaster = 0;
        wait_pulse(2000, got, who, cyc);
        checks++; if (!got || who || cardsLeft !== 6'd51) begin failures++; $display("FAIL middeal_next: got=%0b slave=%0b cards=%0d want master/51", got, who, cardsLeft); end
    endtask
    task automatic test_full_deck();
        int cyc = 0, pulses = 0, bad = 0;
        pulse_reset();
        reqMaster = 1;
        do begin
            @(negedge clock);
            cyc++;
            if (cardReadySlave) bad++;
            if (cardReadyMaster) begin
                pulses++;
                m_hist[cardValue4]++;
            end
        end while (!deckEmpty && cyc < 60000);
        checks++; if (pulses != 52 || bad != 0) begin failures++; $display("FAIL full_pulses: got %0d slave=%0d want 52/0", pulses, bad); end
        for (int v = 2; v <= 11; v++) begin
            checks++; if (m_hist[v] != cap(v)) begin failures++; $display("FAIL full_hist[%0d]: got %0d want %0d", v, m_hist[v], cap(v)); end
        end
        checks++; if (cardsLeft !== 6'd0 || deckEmpty !== 1'b1) begin failures++; $display("FAIL full_empty: cards=%0d empty=%0b want 0/1", cardsLeft, deckEmpty); end
        reqSlave = 1;
        pulses = 0;
        repeat (100) begin
            @(negedge clock);
            if (cardReadyMaster || cardReadySlave) pulses++;
        end
        checks++; if (pulses != 0 || busy !== 1'b0 || deckEmpty !== 1'b1) begin failures++; $display("FAIL full_after: pulses=%0d busy=%0b empty=%0b want 0/0/1", pulses, busy, deckEmpty); end
        reqMaster = 0; reqSlave = 0;
    endtask
    initial begin
        model_reset();
        @(negedge clock);
        test_reset();
        test_single();
        test_alternation();
        test_finish_gating();
        test_random();
        test_reset_mid_deal();
        test_full_deck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
